// File: rtl/comp_sequencer_if.sv
// Requester/consumer bundle for comp_sequencer: two operand requesters in, one result out.
// The master side drives requests and rsp_ready; the slave side (the sequencer) answers.
interface comp_sequencer_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic       rsp_eq;
  logic       rsp_gt;
  logic       busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, busy
  );
endinterface

// File: rtl/comp_sequencer.sv
// Two-requester unsigned 8-bit comparator that walks the operands in 2-bit slices, MSB first,
// with round-robin arbitration and an optional early exit on the first unequal slice.
module comp_sequencer #(
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  comp_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t     r_state;
  logic       r_last;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_id;
  logic       r_eq;
  logic       r_gt;
  logic [1:0] r_idx;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic       r_rsp_eq;
  logic       r_rsp_gt;
  logic       r_busy;

  logic [1:0] w_a_sl [4];
  logic [1:0] w_b_sl [4];
  logic [1:0] w_a_s;
  logic [1:0] w_b_s;
  logic       w_eq_next;
  logic       w_gt_next;
  logic       w_last_slice;
  logic       w_any_req;
  logic       w_grant1;
  logic       w_idle;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign w_a_sl[gi] = r_a[2*gi+1:2*gi];
      assign w_b_sl[gi] = r_b[2*gi+1:2*gi];
    end
  endgenerate

  assign w_a_s     = w_a_sl[r_idx];
  assign w_b_s     = w_b_sl[r_idx];
  assign w_eq_next = r_eq & (w_a_s == w_b_s);
  // Only the first differing slice (while still equal above it) decides ordering.
  assign w_gt_next = r_gt | (r_eq & (w_a_s > w_b_s));
  assign w_last_slice = (r_idx == 2'd0) || ((EARLY_EXIT != 0) && !w_eq_next);

  // r_last holds the previously granted id; the other requester wins a tie.
  assign w_any_req = bus.req0_valid | bus.req1_valid;
  assign w_grant1  = bus.req1_valid & (~bus.req0_valid | ~r_last);
  assign w_idle    = (r_state == IDLE) & ~reset;

  assign bus.req0_ready = w_idle & w_any_req & ~w_grant1;
  assign bus.req1_ready = w_idle & w_grant1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_eq     = r_rsp_eq;
  assign bus.rsp_gt     = r_rsp_gt;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_id        <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_idx       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_eq    <= 1'b0;
      r_rsp_gt    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= w_grant1 ? bus.req1_a : bus.req0_a;
            r_b     <= w_grant1 ? bus.req1_b : bus.req0_b;
            r_id    <= w_grant1;
            r_last  <= w_grant1;
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_idx   <= 2'd3;
          end
        end
        RUN: begin
          r_eq  <= w_eq_next;
          r_gt  <= w_gt_next;
          r_idx <= r_idx - 2'd1;
          if (w_last_slice) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_eq    <= w_eq_next;
            r_rsp_gt    <= w_gt_next;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
